// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: state encoding,
// supported baud rates, and the 16x oversampling divisor calculation.
package uart_pkg;

   localparam int unsigned OVS         = 32'd16;
   localparam int unsigned BAUD_9600   = 32'd9600;
   localparam int unsigned BAUD_19200  = 32'd19200;
   localparam int unsigned BAUD_57600  = 32'd57600;
   localparam int unsigned BAUD_115200 = 32'd115200;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   // Clocks per oversample tick for a given baud select, rounded down.
   function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [1:0] sel);
      int unsigned baud;
      case (sel)
         2'b00:   baud = BAUD_9600;
         2'b01:   baud = BAUD_19200;
         2'b10:   baud = BAUD_57600;
         default: baud = BAUD_115200;
      endcase
      return clk_hz / (baud * OVS);
   endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks for the
// selected baud rate. Any change of the baud select restarts the count.
import uart_pkg::*;

module uart_baud_tick_gen #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [1:0] S,
   output logic       tick
);

   localparam int unsigned DIV_0   = baud_div(CLK_FREQ_HZ, 2'b00);
   localparam int unsigned DIV_1   = baud_div(CLK_FREQ_HZ, 2'b01);
   localparam int unsigned DIV_2   = baud_div(CLK_FREQ_HZ, 2'b10);
   localparam int unsigned DIV_3   = baud_div(CLK_FREQ_HZ, 2'b11);
   // The slowest baud has the largest divisor and sets the counter width.
   localparam int unsigned CW      = (DIV_0 > 32'd1) ? $clog2(DIV_0) : 32'd1;
   localparam logic [CW-1:0] LAST_0 = CW'(DIV_0 - 32'd1);
   localparam logic [CW-1:0] LAST_1 = CW'(DIV_1 - 32'd1);
   localparam logic [CW-1:0] LAST_2 = CW'(DIV_2 - 32'd1);
   localparam logic [CW-1:0] LAST_3 = CW'(DIV_3 - 32'd1);

   logic [CW-1:0] cnt_d, cnt_q;
   logic [CW-1:0] last_s;
   logic [1:0]    s_d, s_q;
   logic          tick_d, tick_q;

   // Terminal count for the currently selected baud rate.
   always_comb begin
      case (S)
         2'b00:   last_s = LAST_0;
         2'b01:   last_s = LAST_1;
         2'b10:   last_s = LAST_2;
         default: last_s = LAST_3;
      endcase
   end

   // Next counter value; a baud change restarts the count from zero.
   always_comb begin
      s_d    = S;
      tick_d = 1'b0;
      cnt_d  = cnt_q;
      if (S != s_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == last_s) begin
         cnt_d  = {CW{1'b0}};
         tick_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1'b1);
      end
   end

   // Divisor state and registered tick.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt_q  <= {CW{1'b0}};
         s_q    <= S;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         s_q    <= s_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/uart_receiver_controller.sv
// 8N1 UART receiver: synchronizes the serial line, oversamples it at 16x
// baud, validates start/stop bits and presents each byte with a strobe.
import uart_pkg::*;

module uart_receiver_controller #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [1:0] S,
   input  logic       ser_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   // Sample points within a bit: middle of the start bit, then one full bit apart.
   localparam logic [3:0] SC_MID  = 4'(OVERSAMPLE / 32'd2 - 32'd1);
   localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 32'd1);

   logic [SYNC_STAGES-1:0] sync_d, sync_q;
   logic [1:0]             s_q;
   logic                   rx_s;
   logic                   s_chg_s;
   logic                   tick_s;

   rx_state_t  state_d, state_q;
   logic [3:0] sc_d, sc_q;
   logic [2:0] bit_idx_d, bit_idx_q;
   logic [7:0] shift_d, shift_q;
   logic [7:0] data_out_d, data_out_q;
   logic       data_valid_d, data_valid_q;
   logic       frame_err_d, frame_err_q;
   logic       busy_d, busy_q;

   uart_baud_tick_gen #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ)
   ) u_tick_gen (
      .clk_in (clk_in),
      .reset  (reset),
      .S      (S),
      .tick   (tick_s)
   );

   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign s_chg_s = (S != s_q);

   // Shift the raw line into the synchronizer chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ser_in};
   end

   // Synchronizer flops (idle-high) and last baud select for change detection.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{1'b1}};
         s_q    <= S;
      end else begin
         sync_q <= sync_d;
         s_q    <= S;
      end
   end

   // Receive FSM next-state and output computation.
   always_comb begin
      state_d      = state_q;
      sc_d         = sc_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      frame_err_d  = frame_err_q;
      if (s_chg_s) begin
         // Baud change abandons any frame in flight; outputs are kept.
         state_d   = IDLE;
         sc_d      = 4'd0;
         bit_idx_d = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  sc_d    = 4'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            START: begin
               if (tick_s) begin
                  if (sc_q == SC_MID) begin
                     sc_d = 4'd0;
                     if (!rx_s) begin
                        state_d     = DATA;
                        bit_idx_d   = 3'd0;
                        frame_err_d = 1'b0;
                     end else begin
                        // Line went back high before mid-bit: a glitch, not a start.
                        state_d = IDLE;
                     end
                  end else begin
                     sc_d = sc_q + 4'd1;
                  end
               end else begin
                  sc_d = sc_q;
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (sc_q == SC_LAST) begin
                     sc_d      = 4'd0;
                     shift_d   = {rx_s, shift_q[7:1]};
                     bit_idx_d = bit_idx_q + 3'd1;
                     if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                     end else begin
                        state_d = DATA;
                     end
                  end else begin
                     sc_d = sc_q + 4'd1;
                  end
               end else begin
                  sc_d = sc_q;
               end
            end
            STOP: begin
               if (tick_s) begin
                  if (sc_q == SC_LAST) begin
                     sc_d = 4'd0;
                     if (rx_s) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        frame_err_d  = 1'b0;
                        state_d      = IDLE;
                     end else begin
                        // Bad stop bit: keep the previous byte, wait out a break.
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                     end
                  end else begin
                     sc_d = sc_q + 4'd1;
                  end
               end else begin
                  sc_d = sc_q;
               end
            end
            WAIT_HIGH: begin
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_HIGH;
               end
            end
            default: begin
               state_d   = IDLE;
               sc_d      = 4'd0;
               bit_idx_d = 3'd0;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // Receive FSM state, counters and registered outputs.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= IDLE;
         sc_q         <= 4'd0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sc_q         <= sc_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: doc/uart_receiver_controller.md
Name: uart_receiver_controller

Overview:
- Serial-to-parallel UART receiver, 8N1, LSB first, idle-high line.
- Sits downstream of the UART transmitter and consumes its serial output.
- Uses the same 2-bit baud select encoding as the transmitter.
- Oversamples the line at 16x baud and validates the start and stop bits.
- Presents each received byte with a one-cycle valid strobe and a framing-error flag.

Parameters:
- CLK_FREQ_HZ, 100_000_000, frequency of clk_in in Hz.
- OVERSAMPLE, 16, samples per bit; fixed at 16, and a bench may not override it.
- SYNC_STAGES, 2, number of flip-flops in the ser_in synchronizer (minimum 2).

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- S  input  2  baud select: 00=9600, 01=19200, 10=57600, 11=115200.
- ser_in  input  1  asynchronous serial line, idle high.
- data_out  output  8  last correctly framed byte received.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  stop bit sampled low on the most recent frame.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Single clock domain: clk_in only.
  - Reset is synchronous and active-high, sampled on the rising edge of clk_in.
  - No derived clocks; the baud rate is produced by a tick enable.
- Reset values:
  - data_out=8'h00, data_valid=0, frame_err=0, busy=0.
  - State=IDLE, all synchronizer flops=1, all counters=0.
- Synchronizer: ser_in passes through SYNC_STAGES flops; the FSM sees only the synchronized value rx_s.
- Tick generator:
  - Divisor DIV = CLK_FREQ_HZ / (baud*16), integer division rounded down. At 100 MHz: 651, 325, 108, 54.
  - A counter counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - A change of S resets the counter to 0 and forces the FSM to IDLE.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. The 4-bit sample counter sc advances only on tick.
  - IDLE: when rx_s=0, go to START with sc=0.
  - START: on the tick where sc=7 (mid start bit):
    - if rx_s=0: go to DATA, sc=0, bit index=0, frame_err cleared to 0;
    - if rx_s=1: treat as a glitch and return to IDLE, with no output change.
  - DATA: on the tick where sc=15:
    - shift rx_s into the MSB of an 8-bit shift register, shifting right;
    - increment the bit index;
    - after the 8th bit, go to STOP with sc=0.
  - STOP: on the tick where sc=15 (mid stop bit):
    - if rx_s=1: data_out <= shift register, data_valid=1 for exactly one clk_in cycle, frame_err=0, go to IDLE;
    - if rx_s=0: frame_err=1, data_valid stays 0, data_out is held, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a line held low (break) from retriggering reception.
- frame_err is sticky: it holds until the next validated start bit or reset.
- busy = (state != IDLE).
- Latency: data_valid asserts about 9.5 bit times after the falling edge of ser_in, plus SYNC_STAGES cycles, plus at most one tick period.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after STOP, so there is no required inter-frame gap.
- Reset mid-frame: the partial byte is discarded, outputs return to their reset values, and the receiver waits for the next start edge.
- Simultaneous reset and tick: reset wins.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - baud constants for 9600, 19200, 57600 and 115200;
  - function baud_div(clk_hz, sel) returning DIV;
  - constant OVS=16.
- Sub-module uart_baud_tick_gen with ports clk_in, reset, S and tick. It owns the divisor counter and the restart on S change.
- The FSM, synchronizer and shift register live in the top module.

Test Plan:
- S=11, drive 0xA5 at 115200 8N1 (bit period 54*16 clocks) -> data_out=8'hA5, data_valid high exactly 1 cycle, frame_err=0, busy low afterwards.
- S=11, hold ser_in low for 4 ticks then high -> no data_valid, busy returns to 0 after the mid-start sample, data_out unchanged.
- S=11, send 0x3C with the stop bit driven low, hold low for 2 bit times, then release -> frame_err=1, data_valid never high, data_out keeps its previous value, busy high until the line returns high.
- S=11, send 0x00 then 0xFF with no idle gap -> two data_valid pulses, with data_out 8'h00 then 8'hFF; frame_err=0.
- S=10, assert reset after the 3rd data bit of 0x5A, release, then send 0xC3 -> all outputs at reset values, followed by a single pulse with data_out=8'hC3.
- S=00, send 0x55 at 9600 -> correct byte; data_valid occurs 9.5*651*16 clocks (+/- DIV + 2) after the start edge.
